mskaes_128bits_ks_sched: RTL and testbench
==========================================

MSKAES_128BITS_KS_SCHED -- requirements
Module: mskaes_128bits_ks_sched

Interface
REQ-001 SHALL have parameter d, default 2: number of shares.
REQ-002 SHALL have parameter LATENCY, default 4: register latency of the attached 128-bit key-schedule round.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: master key presented.
REQ-006 SHALL have port in_ready, output, 1: scheduler accepts a master key.
REQ-007 SHALL have port sh_key_in, input, 128*d: shared master key, byte i at [8*d*i +: 8*d], bit b share s at 8*d*i + b*d + s.
REQ-008 SHALL have port rk_valid, output, 1: round key valid.
REQ-009 SHALL have port rk_ready, input, 1: consumer takes the round key.
REQ-010 SHALL have port sh_rk_out, output, 128*d: current shared round key, same layout as sh_key_in.
REQ-011 SHALL have port rk_idx, output, 4: round index of sh_rk_out, 0..10.
REQ-012 SHALL have port sh_ks_key_out, output, 128*d: key driven into the KS round input.
REQ-013 SHALL have port sh_ks_rcon, output, 8*d: shared RCON into the KS round, bit b share s at b*d+s.
REQ-014 SHALL have port sh_ks_key_in, input, 128*d: next key returned by the KS round.

Function
REQ-015 SHALL implement FSM IDLE, EMIT, RUN.
REQ-016 IDLE: in_ready=1 and rk_valid=0. On in_valid=1, SHALL load sh_key_in into the key register, set rk_idx=0, load RCON register 0x01, and go to EMIT.
REQ-017 EMIT: rk_valid=1 and sh_rk_out equals the key register. On rk_ready=1 it SHALL go to RUN with cycle counter 0 if rk_idx<10, else go to IDLE.
REQ-018 rk_valid and sh_rk_out SHALL stay stable while rk_valid=1 and rk_ready=0, with no timeout.
REQ-019 RUN SHALL last exactly LATENCY+1 cycles, counter 0..LATENCY. The key register SHALL be held constant throughout.
REQ-020 sh_ks_key_out SHALL equal the key register in every RUN cycle.
REQ-021 sh_ks_rcon SHALL be all zero except when counter==LATENCY. In that cycle, share 0 of each bit SHALL carry the RCON register bit and all other shares SHALL be 0.
REQ-022 At the edge ending counter==LATENCY, the block SHALL capture sh_ks_key_in into the key register, increment rk_idx, update RCON, and go to EMIT.
REQ-023 RCON update: xtime in GF(2^8) mod 0x11B, giving 01,02,04,08,10,20,40,80,1B,36 for rk_idx 1..10.
REQ-024 A complete run SHALL produce 11 round keys, rk_idx 0..10. After rk_idx=10 is accepted, the block SHALL return to IDLE and in_ready=1 on the next cycle.
REQ-025 in_ready SHALL be 0 in EMIT and RUN. in_valid outside IDLE SHALL be ignored.
REQ-026 Minimum latency from acceptance to key 10: 10*(LATENCY+2)+1 cycles with rk_ready tied 1.
REQ-027 Shares SHALL never be recombined. The only operations on key shares are register and mux, applied share-wise.

Reset
REQ-028 When rst=1 at an edge, the block SHALL go to IDLE and clear the key register, rk_idx, counter and RCON register to 0. This applies in any state, including mid-RUN and mid-EMIT.
REQ-029 During and after reset, outputs SHALL be: in_ready=1 after the reset cycle, rk_valid=0, sh_rk_out=0, rk_idx=0, sh_ks_rcon=0, sh_ks_key_out=0.
REQ-030 Reset SHALL take priority over simultaneous in_valid or rk_ready.

Configuration
REQ-031 Macro MSKAES_KS_ZERO_ON_IDLE_EN defined: sh_ks_key_out SHALL be forced to all-zero outside RUN, and sh_rk_out SHALL be forced to all-zero outside EMIT.
REQ-032 MSKAES_KS_ZERO_ON_IDLE_EN undefined: sh_ks_key_out and sh_rk_out SHALL always equal the key register. Cycle behaviour is otherwise identical.

Verification
REQ-033 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, d=2, random share split, rk_ready=1, KS round attached -> 11 keys recombine to the FIPS schedule, ending d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-034 Hold rk_ready=0 for 7 cycles at rk_idx=3 -> rk_valid and sh_rk_out are stable, no RUN entered, and the sequence resumes correctly.
REQ-035 Monitor sh_ks_rcon over a full run -> nonzero only in counter==LATENCY cycles, share0 = 01..36, other shares 0.
REQ-036 Assert rst during RUN of round 5 -> next cycle IDLE, all outputs 0, and a new key is accepted and scheduled correctly.
REQ-037 in_valid=1 continuously during a run -> ignored; in_ready is 0 until the cycle after key 10 is accepted.
REQ-038 Build with and without MSKAES_KS_ZERO_ON_IDLE_EN, LATENCY=4 and 6 -> identical rk sequence and timing, and zeroed buses outside RUN/EMIT when the macro is defined.

Source files
------------

// File: rtl/mskaes_128bits_ks_sched.sv
// Round-key sequencer for a masked AES-128 key schedule with an external, pipelined KS round.
// Optional MSKAES_KS_ZERO_ON_IDLE_EN: zero the key buses whenever they are not meaningful.
module mskaes_128bits_ks_sched #(
  parameter int d       = 2,
  parameter int LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [128*d-1:0] sh_key_in,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [128*d-1:0] sh_rk_out,
  output logic [3:0]       rk_idx,
  output logic [128*d-1:0] sh_ks_key_out,
  output logic [8*d-1:0]   sh_ks_rcon,
  input  logic [128*d-1:0] sh_ks_key_in
);

  localparam int KW = 128 * d;
  localparam int CW = $clog2(LATENCY + 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_RUN
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   key_q, key_d;
  logic [3:0]      rk_idx_q, rk_idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      rcon_q, rcon_d;
  logic            in_ready_q, in_ready_d;
  logic            rk_valid_q, rk_valid_d;
  logic            rcon_en_q, rcon_en_d;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    rk_idx_d = rk_idx_q;
    cnt_d    = cnt_q;
    rcon_d   = rcon_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          key_d    = sh_key_in;
          rk_idx_d = '0;
          rcon_d   = 8'h01;
          cnt_d    = '0;
          state_d  = S_EMIT;
        end
      end
      S_EMIT: begin
        if (rk_ready) begin
          if (rk_idx_q < 4'd10) begin
            cnt_d   = '0;
            state_d = S_RUN;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_RUN: begin
        // The KS round result is only valid in the cycle RCON is presented.
        if (cnt_q == CNT_LAST) begin
          key_d    = sh_ks_key_in;
          rk_idx_d = rk_idx_q + 4'd1;
          rcon_d   = xtime(rcon_q);
          state_d  = S_EMIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_IDLE);
    rk_valid_d = (state_d == S_EMIT);
    rcon_en_d  = (state_d == S_RUN) && (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      key_q      <= '0;
      rk_idx_q   <= '0;
      cnt_q      <= '0;
      rcon_q     <= '0;
      in_ready_q <= 1'b1;
      rk_valid_q <= 1'b0;
      rcon_en_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      rk_idx_q   <= rk_idx_d;
      cnt_q      <= cnt_d;
      rcon_q     <= rcon_d;
      in_ready_q <= in_ready_d;
      rk_valid_q <= rk_valid_d;
      rcon_en_q  <= rcon_en_d;
    end
  end

  assign in_ready = in_ready_q;
  assign rk_valid = rk_valid_q;
  assign rk_idx   = rk_idx_q;

`ifdef MSKAES_KS_ZERO_ON_IDLE_EN
  assign sh_ks_key_out = (state_q == S_RUN) ? key_q : '0;
  assign sh_rk_out     = rk_valid_q ? key_q : '0;
`else
  assign sh_ks_key_out = key_q;
  assign sh_rk_out     = key_q;
`endif

  // RCON is public, so it rides entirely in share 0; the other shares stay zero.
  always_comb begin
    sh_ks_rcon = '0;
    for (int unsigned b = 0; b < 8; b++) begin
      sh_ks_rcon[b*d] = rcon_en_q & rcon_q[b];
    end
  end

endmodule

// File: tb/tb_mskaes_128bits_ks_sched.sv
// Directed bench for mskaes_128bits_ks_sched with a behavioural (re-masking) AES-128 KS round attached.
module tb_mskaes_128bits_ks_sched;

  localparam int D   = 2;
  localparam int LAT = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [128*D-1:0] sh_key_in;
  logic             rk_valid;
  logic             rk_ready;
  logic [128*D-1:0] sh_rk_out;
  logic [3:0]       rk_idx;
  logic [128*D-1:0] sh_ks_key_out;
  logic [8*D-1:0]   sh_ks_rcon;
  logic [128*D-1:0] sh_ks_key_in;
  logic [127:0]     ks_mask;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mskaes_128bits_ks_sched #(.d(D), .LATENCY(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .sh_key_in    (sh_key_in),
    .rk_valid     (rk_valid),
    .rk_ready     (rk_ready),
    .sh_rk_out    (sh_rk_out),
    .rk_idx       (rk_idx),
    .sh_ks_key_out(sh_ks_key_out),
    .sh_ks_rcon   (sh_ks_rcon),
    .sh_ks_key_in (sh_ks_key_in)
  );

  // AES byte i is k[127-8i -: 8]; shared layout puts bit b, share s at 16i+2b+s.
  function automatic logic [255:0] split(input logic [127:0] k, input logic [127:0] m);
    logic [255:0] s;
    s = '0;
    for (int i = 0; i < 16; i++)
      for (int b = 0; b < 8; b++) begin
        s[16*i+2*b]   = k[120-8*i+b] ^ m[120-8*i+b];
        s[16*i+2*b+1] = m[120-8*i+b];
      end
    return s;
  endfunction

  function automatic logic [127:0] unshare(input logic [255:0] s);
    logic [127:0] k;
    k = '0;
    for (int i = 0; i < 16; i++)
      for (int b = 0; b < 8; b++)
        k[120-8*i+b] = s[16*i+2*b] ^ s[16*i+2*b+1];
    return k;
  endfunction

  function automatic logic [7:0] unshare_rc(input logic [15:0] r);
    logic [7:0] v;
    for (int b = 0; b < 8; b++) v[b] = r[2*b] ^ r[2*b+1];
    return v;
  endfunction

  function automatic logic [15:0] rc_sh(input logic [7:0] v);
    logic [15:0] r;
    r = '0;
    for (int b = 0; b < 8; b++) r[2*b] = v[b];
    return r;
  endfunction

  function automatic logic [7:0] rc_tab(input int i);
    case (i)
      1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
      5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
      9: return 8'h1B; 10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r, e;
    r = 8'h01;
    e = 8'd254;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      if (e[i]) r = gmul(r, a);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] ks_next(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
    t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  assign sh_ks_key_in = split(ks_next(unshare(sh_ks_key_out), unshare_rc(sh_ks_rcon)), ks_mask);

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, ".in_ready"}, in_ready, 1);
    check({tag, ".rk_valid"}, rk_valid, 0);
    check({tag, ".rk_idx"}, rk_idx, 0);
    check({tag, ".rk_out"}, sh_rk_out, 0);
    check({tag, ".ks_key"}, sh_ks_key_out, 0);
    check({tag, ".ks_rcon"}, sh_ks_rcon, 0);
  endtask

  task automatic run_key(input logic [127:0] key, input logic [127:0] last, input int hold_idx,
                         input int rst_round, input bit keep_valid);
    logic [127:0] exp_k;
    logic [255:0] held;
    int cyc;
    bit stop;
    exp_k     = key;
    stop      = 1'b0;
    ks_mask   = rnd128();
    sh_key_in = split(key, rnd128());
    in_valid  = 1'b1;
    rk_ready  = 1'b1;
    check("accept.in_ready", in_ready, 1);
    step();
    cyc      = 1;
    in_valid = keep_valid;
    for (int k = 0; k <= 10 && !stop; k++) begin
      check($sformatf("emit%0d.valid", k), rk_valid, 1);
      check($sformatf("emit%0d.idx", k), rk_idx, k);
      check($sformatf("emit%0d.key", k), unshare(sh_rk_out), exp_k);
      check($sformatf("emit%0d.in_ready", k), in_ready, 0);
      check($sformatf("emit%0d.rcon", k), sh_ks_rcon, 0);
      if (k == hold_idx) begin
        held     = sh_rk_out;
        rk_ready = 1'b0;
        for (int h = 0; h < 7; h++) begin
          step();
          cyc++;
          check("hold.valid", rk_valid, 1);
          check("hold.idx", rk_idx, k);
          check("hold.rk_out", sh_rk_out, held);
          check("hold.rcon", sh_ks_rcon, 0);
        end
        rk_ready = 1'b1;
      end
      if (k == 10) begin
        check("last_key", unshare(sh_rk_out), last);
        if (hold_idx < 0) check("latency", cyc, 10 * (LAT + 2) + 1);
        step();
        in_valid = 1'b0;
        check("done.in_ready", in_ready, 1);
        check("done.rk_valid", rk_valid, 0);
      end else begin
        step();
        cyc++;
        for (int r = 0; r <= LAT && !stop; r++) begin
          check("run.valid", rk_valid, 0);
          check("run.in_ready", in_ready, 0);
          check($sformatf("run%0d.ks_key", k), unshare(sh_ks_key_out), exp_k);
          check($sformatf("run%0d.%0d.rcon", k, r), sh_ks_rcon,
                (r == LAT) ? rc_sh(rc_tab(k + 1)) : 16'h0000);
          if (k == rst_round && r == 2) begin
            rst      = 1'b1;
            in_valid = 1'b1;
            step();
            rst      = 1'b0;
            in_valid = 1'b0;
            check_reset_outs("midrun_rst");
            stop = 1'b1;
          end else begin
            step();
            cyc++;
          end
        end
        if (!stop) exp_k = ks_next(exp_k, rc_tab(k + 1));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    rk_ready  = 1'b0;
    sh_key_in = '0;
    ks_mask   = '0;
    repeat (3) step();
    rst = 1'b0;
    check_reset_outs("reset");

    run_key(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 3, -1, 1'b1);
    step();
    run_key(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0, -1, 5, 1'b0);
    step();
    run_key(128'h000102030405060708090a0b0c0d0e0f, 128'h13111d7fe3944a17f307a78b4d2b30c5, -1, -1, 1'b0);
    step();
    check("idle.rk_valid", rk_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
